mem_access_ctrl: RTL and testbench

MEM-stage initiator for the word-only data memory: accepts one load/store per transaction from the pipeline and drives the memory's Addr/WData/MemWrite/RData port. Sub-word stores (SB, SH) are executed as read-modify-write. Loads are sign- or zero-extended. Misaligned and out-of-range addresses are rejected with an error pulse. The pipeline stalls on `busy` and consumes results on `done`.

---
 rtl/mem_access_ctrl.sv | 178 +++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// MEM-stage initiator for a word-only data memory. Executes one load or store per
// transaction, performs read-modify-write for sub-word stores, extends load results
// and rejects misaligned or out-of-range requests with an error response.
module mem_access_ctrl #(
  parameter int unsigned AW = 12
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        req_valid,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  input  logic [31:0] mem_rdata
);

  localparam logic [2:0] OpLw  = 3'd0;
  localparam logic [2:0] OpLh  = 3'd1;
  localparam logic [2:0] OpLhu = 3'd2;
  localparam logic [2:0] OpLb  = 3'd3;
  localparam logic [2:0] OpLbu = 3'd4;
  localparam logic [2:0] OpSw  = 3'd5;
  localparam logic [2:0] OpSh  = 3'd6;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StStore,
    StRmwRd,
    StRmwWr,
    StResp
  } state_e;

  state_e      state_q;
  logic [2:0]  op_q;
  logic [1:0]  addr_lo_q;
  logic [31:0] wdata_q;
  logic [31:0] merge_q;
  logic        err_q;

  logic        req_bad;
  logic        req_is_load;
  logic [31:0] load_ext;
  logic [31:0] merged;

  // Classify the incoming request: range/alignment error and load vs. store.
  always_comb begin
    req_bad = |req_addr[31:AW];
    case (req_op)
      OpLw, OpSw:        if (req_addr[1:0] != 2'b00) req_bad = 1'b1;
      OpLh, OpLhu, OpSh: if (req_addr[0]) req_bad = 1'b1;
      default: ;
    endcase
    req_is_load = (req_op <= OpLbu);
  end

  // Lane extraction and sign/zero extension of the word currently on mem_rdata.
  always_comb begin
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    case (addr_lo_q)
      2'd0:    lane_b = mem_rdata[7:0];
      2'd1:    lane_b = mem_rdata[15:8];
      2'd2:    lane_b = mem_rdata[23:16];
      default: lane_b = mem_rdata[31:24];
    endcase
    lane_h = addr_lo_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (op_q)
      OpLh:    load_ext = {{16{lane_h[15]}}, lane_h};
      OpLhu:   load_ext = {16'h0000, lane_h};
      OpLb:    load_ext = {{24{lane_b[7]}}, lane_b};
      OpLbu:   load_ext = {24'h000000, lane_b};
      default: load_ext = mem_rdata;
    endcase
  end

  // Replace the target lane of the captured word with the store data.
  always_comb begin
    merged = merge_q;
    if (op_q == OpSh) begin
      if (addr_lo_q[1]) merged[31:16] = wdata_q[15:0];
      else              merged[15:0]  = wdata_q[15:0];
    end else begin
      case (addr_lo_q)
        2'd0:    merged[7:0]   = wdata_q[7:0];
        2'd1:    merged[15:8]  = wdata_q[7:0];
        2'd2:    merged[23:16] = wdata_q[7:0];
        default: merged[31:24] = wdata_q[7:0];
      endcase
    end
  end

  // Write data is decoded from state so it is zero outside the two write cycles.
  always_comb begin
    mem_wdata = '0;
    case (state_q)
      StStore: mem_wdata = wdata_q;
      StRmwWr: mem_wdata = merged;
      default: ;
    endcase
  end

  // Transaction FSM with registered status outputs.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= StIdle;
      op_q      <= '0;
      addr_lo_q <= '0;
      wdata_q   <= '0;
      merge_q   <= '0;
      err_q     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      rdata     <= '0;
      mem_addr  <= '0;
      mem_we    <= 1'b0;
    end else begin
      done   <= 1'b0;
      err    <= 1'b0;
      mem_we <= 1'b0;
      case (state_q)
        // RESP may accept the next request directly, so back-to-back has no idle gap.
        StIdle, StResp: begin
          if (req_valid) begin
            op_q      <= req_op;
            addr_lo_q <= req_addr[1:0];
            wdata_q   <= req_wdata;
            mem_addr  <= {req_addr[31:2], 2'b00};
            err_q     <= req_bad;
            busy      <= 1'b1;
            // Rejected requests spend one quiet cycle in LOAD (no capture) so they
            // share the two-cycle shape of loads and word stores.
            if (req_bad || req_is_load) begin
              state_q <= StLoad;
            end else if (req_op == OpSw) begin
              state_q <= StStore;
              mem_we  <= 1'b1;
            end else begin
              state_q <= StRmwRd;
            end
          end else begin
            state_q <= StIdle;
            busy    <= 1'b0;
            err_q   <= 1'b0;
          end
        end
        StLoad: begin
          if (!err_q) rdata <= load_ext;
          state_q <= StResp;
          done    <= 1'b1;
          err     <= err_q;
        end
        StStore: begin
          state_q <= StResp;
          done    <= 1'b1;
        end
        StRmwRd: begin
          merge_q <= mem_rdata;
          state_q <= StRmwWr;
          mem_we  <= 1'b1;
        end
        StRmwWr: begin
          state_q <= StResp;
          done    <= 1'b1;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed scenarios plus randomized
// transactions against a transaction-level model of the memory and the outputs.
module tb_mem_access_ctrl;
  localparam int unsigned AW = 12;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        req_valid;
  logic [2:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] rdata;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [31:0] mem_rdata;

  mem_access_ctrl #(.AW(AW)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .req_valid (req_valid),
    .req_op    (req_op),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .rdata     (rdata),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_rdata (mem_rdata)
  );

  always #5 Clk = ~Clk;

  // Memory seen by the DUT, and the reference image the model maintains.
  logic [31:0] mem     [1024];
  logic [31:0] ref_mem [1024];

  assign mem_rdata = mem[mem_addr[AW-1:2]];

  always @(posedge Clk) begin
    if (mem_we) mem[mem_addr[AW-1:2]] <= mem_wdata;
  end

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  logic        exp_busy, exp_done, exp_err, exp_we;
  logic [31:0] exp_wdata, exp_addr, exp_rdata;
  logic [31:0] m_addr  = '0;
  logic [31:0] m_rdata = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // Single compare process: every cycle, away from the active edge.
  always @(negedge Clk) begin
    if (chk_en) begin
      chk("busy",      32'(busy),   32'(exp_busy));
      chk("done",      32'(done),   32'(exp_done));
      chk("err",       32'(err),    32'(exp_err));
      chk("mem_we",    32'(mem_we), 32'(exp_we));
      chk("mem_wdata", mem_wdata,   exp_wdata);
      chk("mem_addr",  mem_addr,    exp_addr);
      chk("rdata",     rdata,       exp_rdata);
    end
  end

  function automatic logic is_bad(input logic [2:0] op, input logic [31:0] addr);
    logic bad;
    bad = (addr >> AW) != 0;
    if ((op == 3'd0 || op == 3'd5) && addr[1:0] != 2'b00) bad = 1'b1;
    if ((op == 3'd1 || op == 3'd2 || op == 3'd6) && addr[0]) bad = 1'b1;
    return bad;
  endfunction

  function automatic logic [31:0] ext_load(input logic [2:0] op, input logic [31:0] addr,
                                           input logic [31:0] word);
    logic [31:0] b, h;
    b = (word >> (8 * int'(addr[1:0]))) & 32'h0000_00FF;
    h = (word >> (16 * int'(addr[1]))) & 32'h0000_FFFF;
    case (op)
      3'd0:    return word;
      3'd1:    return h[15] ? (h | 32'hFFFF_0000) : h;
      3'd2:    return h;
      3'd3:    return b[7] ? (b | 32'hFFFF_FF00) : b;
      3'd4:    return b;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] store_word(input logic [2:0] op, input logic [31:0] addr,
                                             input logic [31:0] word, input logic [31:0] wd);
    logic [31:0] mask;
    int sh;
    if (op == 3'd5) return wd;
    mask = (op == 3'd6) ? 32'h0000_FFFF : 32'h0000_00FF;
    sh   = (op == 3'd6) ? 16 * int'(addr[1]) : 8 * int'(addr[1:0]);
    return (word & ~(mask << sh)) | ((wd & mask) << sh);
  endfunction

  task automatic set_exp(input logic b, input logic d, input logic e, input logic we,
                         input logic [31:0] wd);
    exp_busy  = b;
    exp_done  = d;
    exp_err   = e;
    exp_we    = we;
    exp_wdata = wd;
    exp_addr  = m_addr;
    exp_rdata = m_rdata;
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    req_op    = 3'($urandom);
    req_addr  = $urandom;
    req_wdata = $urandom;
    repeat (n) begin
      @(posedge Clk);
      #1;
      set_exp(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    end
  endtask

  // Present one request (held until done) and set expectations for each cycle.
  // Returns in the done cycle so the caller can present the next request at once.
  task automatic txn(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd);
    logic        bad, st, sub, we;
    logic [31:0] word, wv;
    int          lat;
    bad  = is_bad(op, addr);
    st   = (op >= 3'd5);
    sub  = (op >= 3'd6);
    word = ref_mem[addr[AW-1:2]];
    lat  = (!bad && sub) ? 3 : 2;
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    req_wdata = wd;
    m_addr    = {addr[31:2], 2'b00};
    for (int i = 1; i <= lat; i++) begin
      @(posedge Clk);
      #1;
      we = 1'b0;
      wv = 32'h0;
      if (!bad && st && i == lat - 1) begin
        we = 1'b1;
        wv = store_word(op, addr, word, wd);
      end
      if (i == lat && !bad && !st) m_rdata = ext_load(op, addr, word);
      set_exp(1'b1, i == lat, (i == lat) && bad, we, wv);
    end
    if (!bad && st) ref_mem[addr[AW-1:2]] = store_word(op, addr, word, wd);
  endtask

  task automatic put_word(input logic [31:0] addr, input logic [31:0] val);
    mem[addr[AW-1:2]]     = val;
    ref_mem[addr[AW-1:2]] = val;
  endtask

  initial begin
    logic [2:0]  op;
    logic [31:0] addr;
    for (int i = 0; i < 1024; i++) begin
      mem[i]     = $urandom;
      ref_mem[i] = mem[i];
    end
    put_word(32'h10, 32'hDEAD_BEEF);
    put_word(32'h20, 32'h8077_F001);
    put_word(32'h40, 32'h1122_3344);

    Reset     = 1'b1;
    req_valid = 1'b0;
    req_op    = '0;
    req_addr  = '0;
    req_wdata = '0;
    @(posedge Clk);
    @(posedge Clk);
    #1;
    set_exp(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk_en = 1'b1;
    Reset  = 1'b0;
    idle(2);

    // Loads with extension.
    txn(3'd0, 32'h10, $urandom);
    chk("lit_lw", rdata, 32'hDEAD_BEEF);
    txn(3'd3, 32'h23, $urandom);
    chk("lit_lb", rdata, 32'hFFFF_FF80);
    txn(3'd4, 32'h23, $urandom);
    chk("lit_lbu", rdata, 32'h0000_0080);
    txn(3'd1, 32'h22, $urandom);
    chk("lit_lh", rdata, 32'hFFFF_8077);
    txn(3'd2, 32'h20, $urandom);
    chk("lit_lhu", rdata, 32'h0000_F001);
    idle(1);

    // Sub-word stores via read-modify-write.
    txn(3'd7, 32'h41, 32'h0000_00AB);
    idle(1);
    chk("lit_sb_mem", mem[16], 32'h1122_AB44);
    txn(3'd6, 32'h42, 32'h0000_CDEF);
    idle(1);
    chk("lit_sh_mem", mem[16], 32'hCDEF_AB44);

    // Rejected requests: misaligned and out of range.
    txn(3'd5, 32'h102, 32'hFFFF_FFFF);
    txn(3'd1, 32'h05, $urandom);
    txn(3'd0, 32'h1000, $urandom);
    idle(1);
    chk("err_mem_102", mem[64], ref_mem[64]);
    chk("err_mem_04", mem[1], ref_mem[1]);

    // Back-to-back SW then LW with the request held through busy.
    txn(3'd5, 32'h8, 32'h1234_5678);
    txn(3'd0, 32'h8, $urandom);
    chk("lit_b2b_rdata", rdata, 32'h1234_5678);
    idle(1);
    chk("lit_b2b_mem", mem[2], 32'h1234_5678);

    // Reset while an SB sits in its read cycle.
    req_valid = 1'b1;
    req_op    = 3'd7;
    req_addr  = 32'h40;
    req_wdata = 32'h0000_0055;
    m_addr    = 32'h40;
    @(posedge Clk);
    #1;
    set_exp(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    Reset     = 1'b1;
    req_valid = 1'b0;
    @(posedge Clk);
    #1;
    m_addr  = '0;
    m_rdata = '0;
    set_exp(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    Reset = 1'b0;
    idle(2);
    chk("lit_rst_mem", mem[16], 32'hCDEF_AB44);

    // Randomized traffic concentrated on a small window to force reuse.
    repeat (300) begin
      op   = 3'($urandom_range(0, 7));
      addr = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 15) == 0) addr[$urandom_range(AW, 31)] = 1'b1;
      txn(op, addr, $urandom);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
    end
    idle(2);
    for (int i = 0; i < 64; i++) chk("final_mem", mem[i], ref_mem[i]);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
